// File: rtl/register_file_rename.sv
// register_file_rename: architectural register file with per-register ROB rename tags and commit bypass.
module register_file_rename #(
  parameter int TAG_W = 4,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rollback_in,
  input  logic             dec_issue_in,
  input  logic [4:0]       dec_rs1_in,
  input  logic [4:0]       dec_rs2_in,
  input  logic [4:0]       dec_rd_in,
  input  logic [TAG_W-1:0] dec_rd_tag_in,
  output logic [XLEN-1:0]  dec_Vj_out,
  output logic [XLEN-1:0]  dec_Vk_out,
  output logic [TAG_W-1:0] dec_Qj_out,
  output logic [TAG_W-1:0] dec_Qk_out,
  input  logic             commit_rf_signal_in,
  input  logic [TAG_W-1:0] commit_tag_in,
  input  logic [XLEN-1:0]  commit_data_in,
  input  logic [4:0]       commit_target_in
);
  logic [XLEN-1:0]  data [32];
  logic [TAG_W-1:0] tags [32];
  logic             hit_j, hit_k;
  // Commit data forwards on target match; the tag only clears if the committer is still the latest producer.
  always_comb begin
    hit_j = commit_rf_signal_in && commit_target_in == dec_rs1_in;
    hit_k = commit_rf_signal_in && commit_target_in == dec_rs2_in;
    dec_Vj_out = dec_rs1_in == 5'd0 ? '0 : hit_j ? commit_data_in : data[dec_rs1_in];
    dec_Vk_out = dec_rs2_in == 5'd0 ? '0 : hit_k ? commit_data_in : data[dec_rs2_in];
    dec_Qj_out = dec_rs1_in == 5'd0 || (hit_j && tags[dec_rs1_in] == commit_tag_in) ? '0 : tags[dec_rs1_in];
    dec_Qk_out = dec_rs2_in == 5'd0 || (hit_k && tags[dec_rs2_in] == commit_tag_in) ? '0 : tags[dec_rs2_in];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        data[i] <= '0;
        tags[i] <= '0;
      end
    end else begin
      if (commit_rf_signal_in && commit_target_in != 5'd0) data[commit_target_in] <= commit_data_in;
      for (int i = 1; i < 32; i++) begin
        if (rollback_in) tags[i] <= '0;
        else if (dec_issue_in && dec_rd_in == 5'(i)) tags[i] <= dec_rd_tag_in;
        else if (commit_rf_signal_in && commit_target_in == 5'(i) && tags[i] == commit_tag_in) tags[i] <= '0;
      end
    end
  end
endmodule

// File: tb/tb_register_file_rename.sv
// tb_register_file_rename: directed scenarios plus random traffic against an array-based reference model.
module tb_register_file_rename;
  logic        clk = 0, rst, rollback_in, dec_issue_in, commit_rf_signal_in;
  logic [4:0]  dec_rs1_in, dec_rs2_in, dec_rd_in, commit_target_in;
  logic [3:0]  dec_rd_tag_in, commit_tag_in, dec_Qj_out, dec_Qk_out;
  logic [31:0] commit_data_in, dec_Vj_out, dec_Vk_out;
  int checks = 0, errors = 0;
  logic [31:0] md [32];
  logic [3:0]  mt [32];

  register_file_rename dut (
    .clk(clk), .rst(rst), .rollback_in(rollback_in), .dec_issue_in(dec_issue_in),
    .dec_rs1_in(dec_rs1_in), .dec_rs2_in(dec_rs2_in), .dec_rd_in(dec_rd_in),
    .dec_rd_tag_in(dec_rd_tag_in), .dec_Vj_out(dec_Vj_out), .dec_Vk_out(dec_Vk_out),
    .dec_Qj_out(dec_Qj_out), .dec_Qk_out(dec_Qk_out),
    .commit_rf_signal_in(commit_rf_signal_in), .commit_tag_in(commit_tag_in),
    .commit_data_in(commit_data_in), .commit_target_in(commit_target_in));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rb, input logic iss, input logic [4:0] rd,
                       input logic [3:0] rt, input logic cv, input logic [4:0] tg,
                       input logic [3:0] ct, input logic [31:0] cd,
                       input logic [4:0] r1, input logic [4:0] r2);
    rst = r; rollback_in = rb; dec_issue_in = iss; dec_rd_in = rd; dec_rd_tag_in = rt;
    commit_rf_signal_in = cv; commit_target_in = tg; commit_tag_in = ct; commit_data_in = cd;
    dec_rs1_in = r1; dec_rs2_in = r2;
  endtask

  function automatic logic [3:0] exp_q(input logic [4:0] rs);
    if (rs == 0) return 0;
    if (commit_rf_signal_in && commit_target_in == rs && mt[rs] == commit_tag_in) return 0;
    return mt[rs];
  endfunction

  function automatic logic [31:0] exp_v(input logic [4:0] rs);
    if (rs == 0) return 0;
    if (commit_rf_signal_in && commit_target_in == rs) return commit_data_in;
    return md[rs];
  endfunction

  // Value is only meaningful once the tag has resolved, so V is compared only when Q is expected to be 0.
  task automatic settle();
    #2;
    chk("Qj", {28'd0, dec_Qj_out}, {28'd0, exp_q(dec_rs1_in)});
    chk("Qk", {28'd0, dec_Qk_out}, {28'd0, exp_q(dec_rs2_in)});
    if (exp_q(dec_rs1_in) == 0) chk("Vj", dec_Vj_out, exp_v(dec_rs1_in));
    if (exp_q(dec_rs2_in) == 0) chk("Vk", dec_Vk_out, exp_v(dec_rs2_in));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin md[i] = 0; mt[i] = 0; end
    end else begin
      logic clr;
      clr = commit_rf_signal_in && commit_target_in != 0 && mt[commit_target_in] == commit_tag_in;
      if (commit_rf_signal_in && commit_target_in != 0) md[commit_target_in] = commit_data_in;
      if (rollback_in) begin
        for (int i = 0; i < 32; i++) mt[i] = 0;
      end else begin
        if (clr) mt[commit_target_in] = 0;
        if (dec_issue_in && dec_rd_in != 0) mt[dec_rd_in] = dec_rd_tag_in;
      end
    end
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 31);
    settle();
    chk("reset_q1", {28'd0, dec_Qj_out}, 0);
    chk("reset_v31", dec_Vk_out, 0);
    tick();
    // issue, read pending tag, then commit with same-cycle bypass
    drive(0, 0, 1, 5, 3, 0, 0, 0, 0, 5, 5); settle(); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0); settle();
    chk("iss_q5", {28'd0, dec_Qj_out}, 3); tick();
    drive(0, 0, 0, 0, 0, 1, 5, 3, 32'hDEADBEEF, 5, 0); settle();
    chk("byp_v5", dec_Vj_out, 32'hDEADBEEF);
    chk("byp_q5", {28'd0, dec_Qj_out}, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0); settle();
    chk("post_q5", {28'd0, dec_Qj_out}, 0); tick();
    // stale commit keeps newer tag
    drive(0, 0, 1, 7, 2, 0, 0, 0, 0, 7, 0); settle(); tick();
    drive(0, 0, 1, 7, 4, 0, 0, 0, 0, 7, 0); settle(); tick();
    drive(0, 0, 0, 0, 0, 1, 7, 2, 32'h11, 7, 0); settle();
    chk("stale_q7", {28'd0, dec_Qj_out}, 4); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0); settle();
    chk("stale_keep_q7", {28'd0, dec_Qj_out}, 4); tick();
    drive(0, 0, 0, 0, 0, 1, 7, 4, 32'h22, 0, 0); settle(); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0); settle();
    chk("fin_v7", dec_Vj_out, 32'h22);
    chk("fin_q7", {28'd0, dec_Qj_out}, 0); tick();
    // same-edge issue and commit on x9
    drive(0, 0, 1, 9, 1, 0, 0, 0, 0, 0, 0); settle(); tick();
    drive(0, 0, 1, 9, 6, 1, 9, 1, 32'h55, 0, 0); settle(); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9); settle();
    chk("same_q9", {28'd0, dec_Qj_out}, 6); tick();
    drive(0, 0, 0, 0, 0, 1, 9, 6, 32'h55, 9, 0); settle();
    chk("same_v9", dec_Vj_out, 32'h55); tick();
    // rollback with concurrent issue
    drive(0, 0, 0, 0, 0, 1, 3, 0, 32'h33, 0, 0); settle(); tick();
    drive(0, 0, 1, 3, 5, 1, 4, 0, 32'h44, 0, 0); settle(); tick();
    drive(0, 0, 1, 4, 6, 0, 0, 0, 0, 3, 4); settle(); tick();
    drive(0, 1, 1, 8, 7, 0, 0, 0, 0, 3, 4); settle(); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 4); settle();
    chk("rb_q3", {28'd0, dec_Qj_out}, 0);
    chk("rb_v3", dec_Vj_out, 32'h33);
    chk("rb_v4", dec_Vk_out, 32'h44); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0); settle();
    chk("rb_q8", {28'd0, dec_Qj_out}, 0); tick();
    // x0 is hardwired
    drive(0, 0, 1, 0, 2, 1, 0, 0, 32'hFFFFFFFF, 0, 0); settle();
    chk("x0_v_same", dec_Vj_out, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
    chk("x0_v", dec_Vj_out, 0);
    chk("x0_q", {28'd0, dec_Qj_out}, 0); tick();
    // reset beats commit
    drive(0, 0, 1, 1, 9, 0, 0, 0, 0, 0, 0); settle(); tick();
    drive(1, 0, 0, 0, 0, 1, 1, 9, 32'h1234, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5); settle();
    chk("rst_v1", dec_Vj_out, 0);
    chk("rst_q1", {28'd0, dec_Qj_out}, 0);
    chk("rst_v5", dec_Vk_out, 0); tick();
    // random traffic on a small register window to force collisions
    for (int n = 0; n < 600; n++) begin
      logic [4:0] tg;
      logic [3:0] ct;
      tg = 5'($urandom_range(0, 7));
      ct = $urandom_range(0, 1) ? mt[tg] : 4'($urandom_range(1, 15));
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 4, 1'($urandom),
            5'($urandom_range(0, 7)), 4'($urandom_range(1, 15)),
            1'($urandom), tg, ct, $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      if (!rst) settle();
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
